// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types and constants.
// Holds the fetch-entry bundle passed from the prefetch queue to the core.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry (no bypass).
// Ports: clk, reset_ (sync, high), flush, push/din, pop, head, count, empty.
module rv32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_fetch_queue.sv
// Instruction prefetch queue: issues word fetches, queues {pc,inst}, redirects.
// Ports: clk, reset_, imem_addr/req/rdata, inst/inst_pc/valid/ready, redirect/_pc.
module rv32_fetch_queue
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic         inflight_kill;
  logic [CW-1:0] count;
  logic         empty;
  logic         credit;
  logic         issue;
  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  // Reserve a slot for the read in flight so a return never finds it full.
  assign credit = (count + CW'(inflight)) < CW'(DEPTH);
  assign issue  = ~reset_ & ~redirect & credit;

  // A read returning during redirect (or reset) belongs to the old stream.
  assign push = ~reset_ & ~redirect & inflight & ~inflight_kill;

  assign inst_valid = ~reset_ & ~empty;
  assign pop        = inst_valid & inst_ready & ~redirect;

  assign push_entry.pc   = inflight_pc;
  assign push_entry.inst = imem_rdata;

  assign imem_req  = issue;
  assign imem_addr = reset_ ? RESET_PC : fetch_pc;
  assign inst      = inst_valid ? head.inst : '0;
  assign inst_pc   = inst_valid ? head.pc : '0;

  rv32_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .flush  (redirect),
    .push   (push),
    .din    (push_entry),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (reset_) begin
      fetch_pc      <= RESET_PC;
      inflight_pc   <= '0;
      inflight      <= 1'b0;
      inflight_kill <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_kill <= redirect;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed bench for rv32_fetch_queue: vector table plus redirect/reset sequences.
// Memory model returns addr ^ 32'hA5A5_0000 one cycle after each request.
module tb_rv32_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset_;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  rv32_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_req)
      imem_rdata <= imem_addr ^ KEY;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic rdy, logic rd,
                             logic [31:0] rpc, logic ev,
                             logic [31:0] epc, logic ereq,
                             logic [31:0] eaddr);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rd = rd; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.ereq = ereq; r.eaddr = eaddr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s got %h expected %h",
               stepn, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    reset_      = t.rst;
    inst_ready  = t.rdy;
    redirect    = t.rd;
    redirect_pc = t.rpc;
    #1;
    stepn++;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, t.ev});
    chk("inst_pc", inst_pc, t.ev ? t.epc : 32'd0);
    chk("inst", inst, t.ev ? (t.epc ^ KEY) : 32'd0);
    chk("imem_req", {31'd0, imem_req}, {31'd0, t.ereq});
    if (t.ereq || t.rst)
      chk("imem_addr", imem_addr, t.eaddr);
  endtask

  initial begin
    reset_      = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;

    // reset, streaming, reset mid-stream, fill with ready=0, drain
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 1, 8));
    tbl.push_back(v(0, 1, 0, 0, 1, 4, 1, 12));
    tbl.push_back(v(0, 1, 0, 0, 1, 8, 1, 16));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 4));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 12));
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 16));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 16));
    tbl.push_back(v(0, 1, 0, 0, 1, 4, 1, 16));
    tbl.push_back(v(0, 1, 0, 0, 1, 8, 1, 20));
    tbl.push_back(v(0, 1, 0, 0, 1, 12, 1, 24));
    tbl.push_back(v(0, 1, 0, 0, 1, 16, 1, 28));
    tbl.push_back(v(0, 1, 0, 0, 1, 20, 1, 32));

    foreach (tbl[i])
      step(tbl[i]);

    // redirect to 0x103 with 3 queued and one read in flight
    step(v(1, 0, 0, 0, 0, 0, 0, 0));
    step(v(0, 0, 0, 0, 0, 0, 1, 0));
    step(v(0, 0, 0, 0, 0, 0, 1, 4));
    step(v(0, 0, 0, 0, 1, 0, 1, 8));
    step(v(0, 0, 0, 0, 1, 0, 1, 12));
    step(v(0, 0, 1, 32'h103, 1, 0, 0, 0));
    step(v(0, 0, 0, 0, 0, 0, 1, 32'h100));
    step(v(0, 0, 0, 0, 0, 0, 1, 32'h104));
    step(v(0, 1, 0, 0, 1, 32'h100, 1, 32'h108));
    step(v(0, 1, 0, 0, 1, 32'h104, 1, 32'h10C));
    step(v(0, 1, 0, 0, 1, 32'h108, 1, 32'h110));

    // redirect during a pop, then back-to-back redirects
    step(v(0, 1, 1, 32'h200, 1, 32'h10C, 0, 0));
    step(v(0, 1, 1, 32'h300, 0, 0, 0, 0));
    step(v(0, 1, 0, 0, 0, 0, 1, 32'h300));
    step(v(0, 1, 0, 0, 0, 0, 1, 32'h304));
    step(v(0, 1, 0, 0, 1, 32'h300, 1, 32'h308));
    step(v(0, 1, 0, 0, 1, 32'h304, 1, 32'h30C));

    // address wrap at the top of the address space
    step(v(0, 1, 1, 32'hFFFF_FFF8, 1, 32'h308, 0, 0));
    step(v(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFF8));
    step(v(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC));
    step(v(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'h0));
    step(v(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4));
    step(v(0, 1, 0, 0, 1, 32'h0, 1, 32'h8));
    step(v(0, 1, 0, 0, 1, 32'h4, 1, 32'hC));

    // one-cycle reset with the queue full
    step(v(1, 0, 0, 0, 0, 0, 0, 0));
    step(v(0, 0, 0, 0, 0, 0, 1, 0));
    step(v(0, 0, 0, 0, 0, 0, 1, 4));
    step(v(0, 0, 0, 0, 1, 0, 1, 8));
    step(v(0, 0, 0, 0, 1, 0, 1, 12));
    step(v(0, 0, 0, 0, 1, 0, 0, 16));
    step(v(0, 0, 0, 0, 1, 0, 0, 16));
    step(v(1, 0, 0, 0, 0, 0, 0, 0));
    step(v(0, 1, 0, 0, 0, 0, 1, 0));
    step(v(0, 1, 0, 0, 0, 0, 1, 4));
    step(v(0, 1, 0, 0, 1, 0, 1, 8));
    step(v(0, 1, 0, 0, 1, 4, 1, 12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
